// File: rtl/lc3_useq_pkg.sv
// rtl/lc3_useq_pkg.sv - shared encodings for the LC-3 microsequencer
package lc3_useq_pkg;

    typedef enum logic [2:0] {
        COND_NONE  = 3'b000,
        COND_R     = 3'b001,
        COND_BEN   = 3'b010,
        COND_IR11  = 3'b011,
        COND_PSR15 = 3'b100,
        COND_INT   = 3'b101,
        COND_ACV   = 3'b110
    } cond_e;

    typedef enum logic [1:0] {
        SEQ_NORMAL = 2'b00,
        SEQ_CALL   = 2'b01,
        SEQ_RET    = 2'b10
    } seq_op_e;

    localparam int BIT_IR11  = 0;
    localparam int BIT_R     = 1;
    localparam int BIT_BEN   = 2;
    localparam int BIT_PSR15 = 3;
    localparam int BIT_INT   = 4;
    localparam int BIT_ACV   = 5;

endpackage

// File: rtl/useq_return_stack.sv
// rtl/useq_return_stack.sv - micro-return address LIFO
module useq_return_stack #(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [PTR_W-2:0]  top_idx;

    assign full_o  = (sp_q == PTR_W'(STACK_DEPTH));
    assign empty_o = (sp_q == '0);
    // Wraps harmlessly to the last slot when empty; the parent never pops then.
    assign top_idx = (PTR_W-1)'(sp_q - PTR_W'(1));
    assign top_o   = mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o)
            sp_d = sp_q + PTR_W'(1);
        else if (pop_i && !empty_o)
            sp_d = sp_q - PTR_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            sp_q <= sp_d;
            if (push_i && !full_o)
                mem_q[sp_q[PTR_W-2:0]] <= data_i;
        end
    end

endmodule

// File: rtl/microsequencer_stack.sv
// rtl/microsequencer_stack.sv - LC-3 microsequencer with call/return stack and memory-wait timeout
module microsequencer_stack
    import lc3_useq_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int RESET_STATE = 18,
    parameter int STACK_DEPTH = 4,
    parameter int TIMEOUT     = 255,
    parameter int ERR_STATE   = 63
) (
    input  logic              i_CLK,
    input  logic              i_Reset,
    input  logic [ADDR_W-1:0] i_j_field,
    input  logic [2:0]        i_COND_bits,
    input  logic              i_IRD,
    input  logic              i_LD_BEN,
    input  logic [1:0]        i_SEQ_OP,
    input  logic              i_R_Bit,
    input  logic [6:0]        i_IR_15_9,
    input  logic [2:0]        i_NZP,
    input  logic              i_ACV,
    input  logic              i_PSR_15,
    input  logic              i_INT,
    output logic [ADDR_W-1:0] o_State,
    output logic [ADDR_W-1:0] o_AddressNextState,
    output logic              o_BEN,
    output logic              o_MemTimeout,
    output logic              o_StackOverflow,
    output logic              o_StackUnderflow
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [ADDR_W-1:0] state_q, state_d;
    logic              ben_q, ben_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic [ADDR_W-1:0] cond_addr, stack_top;
    logic              r_wait, timeout_fire, seq_active, is_call, is_ret;
    logic              push, pop, full, empty;

    always_comb begin
        cond_addr = i_j_field;
        case (i_COND_bits)
            COND_ACV:   cond_addr[BIT_ACV]   = i_j_field[BIT_ACV]   | i_ACV;
            COND_INT:   cond_addr[BIT_INT]   = i_j_field[BIT_INT]   | i_INT;
            COND_PSR15: cond_addr[BIT_PSR15] = i_j_field[BIT_PSR15] | i_PSR_15;
            COND_BEN:   cond_addr[BIT_BEN]   = i_j_field[BIT_BEN]   | ben_q;
            COND_R:     cond_addr[BIT_R]     = i_j_field[BIT_R]     | i_R_Bit;
            COND_IR11:  cond_addr[BIT_IR11]  = i_j_field[BIT_IR11]  | i_IR_15_9[2];
            default:    cond_addr = i_j_field;
        endcase
    end

    assign r_wait       = (i_COND_bits == COND_R) && !i_R_Bit;
    assign timeout_fire = (TIMEOUT != 0) && r_wait && (cnt_q == CNT_W'(TIMEOUT));

    // Dispatch and timeout both pre-empt the stack, so neither may push or pop.
    assign seq_active = !i_Reset && !i_IRD && !timeout_fire;
    assign is_call    = seq_active && (i_SEQ_OP == SEQ_CALL);
    assign is_ret     = seq_active && (i_SEQ_OP == SEQ_RET);
    assign push       = is_call && !full;
    assign pop        = is_ret && !empty;

    always_comb begin
        if (i_Reset)
            state_d = ADDR_W'(RESET_STATE);
        else if (timeout_fire)
            state_d = ADDR_W'(ERR_STATE);
        else if (i_IRD)
            state_d = {{(ADDR_W-4){1'b0}}, i_IR_15_9[6:3]};
        else if (is_ret)
            state_d = empty ? ADDR_W'(RESET_STATE) : stack_top;
        else
            state_d = cond_addr;
    end

    always_comb begin
        ben_d = i_LD_BEN ? ((i_IR_15_9[2] & i_NZP[2]) | (i_IR_15_9[1] & i_NZP[1]) |
                            (i_IR_15_9[0] & i_NZP[0])) : ben_q;
        cnt_d = (TIMEOUT == 0 || timeout_fire || !r_wait) ? '0 : cnt_q + CNT_W'(1);
        ovf_d = ovf_q | (is_call && full);
        udf_d = udf_q | (is_ret && empty);
    end

    always_ff @(posedge i_CLK or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ADDR_W'(RESET_STATE);
            ben_q   <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ben_q   <= ben_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    useq_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk_i   (i_CLK),
        .rst_i   (i_Reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (state_q + ADDR_W'(1)),
        .top_o   (stack_top),
        .full_o  (full),
        .empty_o (empty)
    );

    assign o_State            = state_q;
    assign o_AddressNextState = state_d;
    assign o_BEN              = ben_q;
    assign o_MemTimeout       = timeout_fire && !i_Reset;
    assign o_StackOverflow    = ovf_q;
    assign o_StackUnderflow   = udf_q;

endmodule
